sme_ctrl: RTL and testbench

SME_CTRL -- requirements
Module: sme_ctrl

---
 rtl/sme_pkg.sv | 29 ++
 rtl/sme_ctrl_if.sv | 30 +++
 rtl/sme_ctrl_buf.sv | 22 ++
 rtl/sme_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_sme_ctrl.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sme_pkg.sv
// Shared encodings, state enum and character constants for the string-match controller.
package sme_pkg;

    typedef enum logic [1:0] {
        CMD_STR   = 2'd0,
        CMD_PAT   = 2'd1,
        CMD_END   = 2'd2,
        CMD_FLUSH = 2'd3
    } cmd_e;

    typedef enum logic [2:0] {
        COLLECT,
        SEND_STR,
        SEND_PAT,
        GAP,
        WAIT,
        RESP
    } state_e;

    localparam logic [7:0] CH_CARET  = 8'd94;
    localparam logic [7:0] CH_DOLLAR = 8'd36;
    localparam logic [7:0] CH_DOT    = 8'd46;
    localparam logic [7:0] CH_SPACE  = 8'd32;

    localparam int STR_MAX_DEF = 32;
    localparam int PAT_MAX_DEF = 10;
    localparam int TMO_CYC_DEF = 64;

endpackage

// File: rtl/sme_ctrl_if.sv
// Host command, matcher engine and result channels of the string-match controller.
interface sme_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_type;
    logic [7:0] cmd_data;
    logic [7:0] eng_chardata;
    logic       eng_isstring;
    logic       eng_ispattern;
    logic       eng_match;
    logic [4:0] eng_match_index;
    logic       eng_valid;
    logic       res_valid;
    logic       res_ready;
    logic       res_match;
    logic [4:0] res_index;
    logic       res_err;

    modport slave (
        input  cmd_valid, cmd_type, cmd_data, eng_match, eng_match_index, eng_valid, res_ready,
        output cmd_ready, eng_chardata, eng_isstring, eng_ispattern, res_valid, res_match,
               res_index, res_err
    );

    modport master (
        output cmd_valid, cmd_type, cmd_data, eng_match, eng_match_index, eng_valid, res_ready,
        input  cmd_ready, eng_chardata, eng_isstring, eng_ispattern, res_valid, res_match,
               res_index, res_err
    );
endinterface

// File: rtl/sme_ctrl_buf.sv
// Generic byte register file: one synchronous write port, one asynchronous read port.
module sme_ctrl_buf #(
    parameter int DEPTH = 32,
    parameter int W     = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);
    // Rounded up to a power of two so every address is in range.
    logic [W-1:0] mem_q [2**AW];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/sme_ctrl.sv
// String-match controller: buffers host string/pattern bytes and replays them to the matcher.
// Optional watchdog in WAIT enabled by defining SME_CTRL_TIMEOUT_EN.
module sme_ctrl
    import sme_pkg::*;
#(
    parameter int STR_MAX = STR_MAX_DEF,
    parameter int PAT_MAX = PAT_MAX_DEF,
    parameter int TMO_CYC = TMO_CYC_DEF
) (
    input logic       clk,
    input logic       reset,
    sme_ctrl_if.slave bus
);
    localparam int SAW = $clog2(STR_MAX);
    localparam int PAW = $clog2(PAT_MAX);
    localparam int SCW = SAW + 1;
    localparam int PCW = PAW + 1;
    localparam logic [SCW-1:0] STR_LIM = SCW'(STR_MAX);
    localparam logic [PCW-1:0] PAT_LIM = PCW'(PAT_MAX);

    state_e         state_q;
    logic [SCW-1:0] str_cnt_q, sidx_q;
    logic [PCW-1:0] pat_cnt_q, pidx_q;
    logic           str_new_q, ovf_q;
    logic           cmd_ready_q, isstr_q, ispat_q, res_valid_q, res_match_q, res_err_q;
    logic [7:0]     chardata_q;
    logic [4:0]     res_index_q;

    cmd_e           cmd_t;
    logic           cmd_fire;
    logic [SCW-1:0] str_base_d;
    logic           str_full_d, pat_full_d, str_we_d, pat_we_d;
    logic [SAW-1:0] str_raddr_d;
    logic [PAW-1:0] pat_raddr_d;
    logic [7:0]     str_rdata_d, pat_rdata_d;

    assign cmd_t      = cmd_e'(bus.cmd_type);
    assign cmd_fire   = bus.cmd_valid && cmd_ready_q;
    // A retained (already sent) string is overwritten from index 0 by the next string byte.
    assign str_base_d = str_new_q ? str_cnt_q : '0;
    assign str_full_d = (str_base_d == STR_LIM);
    assign pat_full_d = (pat_cnt_q == PAT_LIM);
    assign str_we_d   = cmd_fire && (cmd_t == CMD_STR) && !str_full_d;
    assign pat_we_d   = cmd_fire && (cmd_t == CMD_PAT) && !pat_full_d;

    always_comb begin
        str_raddr_d = '0;
        pat_raddr_d = '0;
        if (state_q == SEND_STR) str_raddr_d = sidx_q[SAW-1:0];
        if (state_q == SEND_PAT) pat_raddr_d = pidx_q[PAW-1:0];
    end

    sme_ctrl_buf #(.DEPTH(STR_MAX), .W(8)) u_str_buf (
        .clk     (clk),
        .we_i    (str_we_d),
        .waddr_i (str_base_d[SAW-1:0]),
        .wdata_i (bus.cmd_data),
        .raddr_i (str_raddr_d),
        .rdata_o (str_rdata_d)
    );

    sme_ctrl_buf #(.DEPTH(PAT_MAX), .W(8)) u_pat_buf (
        .clk     (clk),
        .we_i    (pat_we_d),
        .waddr_i (pat_cnt_q[PAW-1:0]),
        .wdata_i (bus.cmd_data),
        .raddr_i (pat_raddr_d),
        .rdata_o (pat_rdata_d)
    );

`ifdef SME_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(TMO_CYC) + 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);
    logic [TW-1:0] wdog_q;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= COLLECT;
            str_cnt_q   <= '0;
            sidx_q      <= '0;
            pat_cnt_q   <= '0;
            pidx_q      <= '0;
            str_new_q   <= 1'b0;
            ovf_q       <= 1'b0;
            cmd_ready_q <= 1'b0;
            isstr_q     <= 1'b0;
            ispat_q     <= 1'b0;
            chardata_q  <= '0;
            res_valid_q <= 1'b0;
            res_match_q <= 1'b0;
            res_index_q <= '0;
            res_err_q   <= 1'b0;
`ifdef SME_CTRL_TIMEOUT_EN
            wdog_q      <= '0;
`endif
        end else begin
            case (state_q)
                COLLECT: begin
                    cmd_ready_q <= 1'b1;
                    if (cmd_fire) begin
                        case (cmd_t)
                            CMD_STR: begin
                                if (str_full_d) ovf_q <= 1'b1;
                                else begin
                                    str_cnt_q <= str_base_d + SCW'(1);
                                    str_new_q <= 1'b1;
                                end
                            end
                            CMD_PAT: begin
                                if (pat_full_d) ovf_q <= 1'b1;
                                else            pat_cnt_q <= pat_cnt_q + PCW'(1);
                            end
                            CMD_FLUSH: begin
                                str_cnt_q <= '0;
                                str_new_q <= 1'b0;
                            end
                            CMD_END: begin
                                cmd_ready_q <= 1'b0;
                                if (ovf_q || (pat_cnt_q == '0)) begin
                                    state_q     <= RESP;
                                    res_valid_q <= 1'b1;
                                    res_err_q   <= 1'b1;
                                    res_match_q <= 1'b0;
                                    res_index_q <= '0;
                                end else begin
                                    // First byte goes out on this edge for single-cycle latency.
                                    str_new_q <= 1'b0;
                                    if (str_new_q && (str_cnt_q != '0)) begin
                                        state_q    <= SEND_STR;
                                        isstr_q    <= 1'b1;
                                        chardata_q <= str_rdata_d;
                                        sidx_q     <= SCW'(1);
                                    end else begin
                                        state_q    <= SEND_PAT;
                                        ispat_q    <= 1'b1;
                                        chardata_q <= pat_rdata_d;
                                        pidx_q     <= PCW'(1);
                                    end
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                SEND_STR: begin
                    if (sidx_q == str_cnt_q) begin
                        state_q    <= SEND_PAT;
                        isstr_q    <= 1'b0;
                        ispat_q    <= 1'b1;
                        chardata_q <= pat_rdata_d;
                        pidx_q     <= PCW'(1);
                    end else begin
                        chardata_q <= str_rdata_d;
                        sidx_q     <= sidx_q + SCW'(1);
                    end
                end
                SEND_PAT: begin
                    if (pidx_q == pat_cnt_q) begin
                        state_q    <= GAP;
                        ispat_q    <= 1'b0;
                        chardata_q <= '0;
                    end else begin
                        chardata_q <= pat_rdata_d;
                        pidx_q     <= pidx_q + PCW'(1);
                    end
                end
                GAP: begin
                    state_q <= WAIT;
`ifdef SME_CTRL_TIMEOUT_EN
                    wdog_q  <= '0;
`endif
                end
                WAIT: begin
                    if (bus.eng_valid) begin
                        state_q     <= RESP;
                        res_valid_q <= 1'b1;
                        res_match_q <= bus.eng_match;
                        res_index_q <= bus.eng_match_index;
                        res_err_q   <= 1'b0;
                    end
`ifdef SME_CTRL_TIMEOUT_EN
                    // The matcher state is unknown after a timeout, so force a string resend.
                    else if (wdog_q == TMO_LAST) begin
                        state_q     <= RESP;
                        res_valid_q <= 1'b1;
                        res_match_q <= 1'b0;
                        res_index_q <= '0;
                        res_err_q   <= 1'b1;
                        str_new_q   <= 1'b1;
                    end else begin
                        wdog_q <= wdog_q + TW'(1);
                    end
`endif
                end
                RESP: begin
                    if (bus.res_ready) begin
                        state_q     <= COLLECT;
                        cmd_ready_q <= 1'b1;
                        res_valid_q <= 1'b0;
                        res_match_q <= 1'b0;
                        res_index_q <= '0;
                        res_err_q   <= 1'b0;
                        pat_cnt_q   <= '0;
                        ovf_q       <= 1'b0;
                    end
                end
                default: state_q <= COLLECT;
            endcase
        end
    end

    assign bus.cmd_ready     = cmd_ready_q;
    assign bus.eng_chardata  = chardata_q;
    assign bus.eng_isstring  = isstr_q;
    assign bus.eng_ispattern = ispat_q;
    assign bus.res_valid     = res_valid_q;
    assign bus.res_match     = res_match_q;
    assign bus.res_index     = res_index_q;
    assign bus.res_err       = res_err_q;
endmodule

// File: tb/tb_sme_ctrl.sv
// Directed bench for sme_ctrl: host commands in, engine strobes captured, matcher replies driven.
module tb_sme_ctrl;
    import sme_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    sme_ctrl_if bus();

    sme_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;

    int ns, np;
    bit lat, bad, tmo;

    task automatic send(input logic [1:0] t, input logic [7:0] d);
        int w;
        w = 0;
        while (bus.cmd_ready !== 1'b1 && w < 50) begin @(negedge clk); w++; end
        checks++;
        if (w >= 50) begin errs++; $display("FAIL send_ready got=%b want=1", bus.cmd_ready); end
        bus.cmd_valid = 1'b1; bus.cmd_type = t; bus.cmd_data = d;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic load(input string s, input string p);
        for (int i = 0; i < s.len(); i++) send(CMD_STR, s[i]);
        for (int i = 0; i < p.len(); i++) send(CMD_PAT, p[i]);
        send(CMD_END, 8'd0);
    endtask

    // Runs from the negedge after the job end; returns positioned at the gap cycle.
    task automatic grab(input string es, input string ep);
        bit done, seen_pat;
        int cyc;
        ns = 0; np = 0; bad = 0; done = 0; seen_pat = 0; cyc = 0;
        lat = bus.eng_isstring | bus.eng_ispattern;
        while (!done && cyc < 100) begin
            if (bus.eng_isstring && bus.eng_ispattern) bad = 1;
            if (bus.eng_isstring) begin
                if (seen_pat || ns >= es.len() || bus.eng_chardata !== es[ns]) bad = 1;
                ns++;
            end else if (bus.eng_ispattern) begin
                seen_pat = 1;
                if (np >= ep.len() || bus.eng_chardata !== ep[np]) bad = 1;
                np++;
            end else begin
                done = 1;
                if (bus.eng_chardata !== 8'd0) bad = 1;
            end
            if (!done) begin @(negedge clk); cyc++; end
        end
        tmo = !done;
    endtask

    // A bogus reply during the gap cycle must be ignored; the real one is given in WAIT.
    task automatic reply(input bit m, input logic [4:0] mi);
        bus.eng_valid = 1'b1; bus.eng_match = ~m; bus.eng_match_index = 5'd31;
        @(negedge clk);
        bus.eng_match = m; bus.eng_match_index = mi;
        @(negedge clk);
        bus.eng_valid = 1'b0; bus.eng_match = 1'b0; bus.eng_match_index = '0;
    endtask

    task automatic take_result();
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.cmd_ready !== 1'b0) begin errs++; $display("FAIL rst_ready got=%b want=0", bus.cmd_ready); end
        checks++;
        if ({bus.eng_isstring, bus.eng_ispattern, bus.eng_chardata} !== 10'd0) begin
            errs++; $display("FAIL rst_eng got=%b/%b/%h want=0/0/00", bus.eng_isstring, bus.eng_ispattern, bus.eng_chardata);
        end
        checks++;
        if ({bus.res_valid, bus.res_match, bus.res_index, bus.res_err} !== 8'd0) begin
            errs++; $display("FAIL rst_res got=%b%b%h%b want=0", bus.res_valid, bus.res_match, bus.res_index, bus.res_err);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.cmd_ready !== 1'b1) begin errs++; $display("FAIL rst_release_ready got=%b want=1", bus.cmd_ready); end
    endtask

    task automatic test_basic();
        load("ab cd", "cd");
        grab("ab cd", "cd");
        checks++; if (lat !== 1'b1) begin errs++; $display("FAIL basic_latency got=%b want=1", lat); end
        checks++; if (ns != 5) begin errs++; $display("FAIL basic_str_beats got=%0d want=5", ns); end
        checks++; if (np != 2) begin errs++; $display("FAIL basic_pat_beats got=%0d want=2", np); end
        checks++; if (bad || tmo) begin errs++; $display("FAIL basic_seq bad=%b tmo=%b want=0/0", bad, tmo); end
        reply(1'b1, 5'd3);
        checks++;
        if ({bus.res_valid, bus.res_err, bus.cmd_ready} !== 3'b100) begin
            errs++; $display("FAIL basic_resp valid/err/ready got=%b%b%b want=100", bus.res_valid, bus.res_err, bus.cmd_ready);
        end
        checks++; if (bus.res_match !== 1'b1) begin errs++; $display("FAIL basic_match got=%b want=1", bus.res_match); end
        checks++; if (bus.res_index !== 5'd3) begin errs++; $display("FAIL basic_index got=%0d want=3", bus.res_index); end
        take_result();
        checks++;
        if ({bus.res_valid, bus.cmd_ready} !== 2'b01) begin
            errs++; $display("FAIL basic_release valid/ready got=%b%b want=01", bus.res_valid, bus.cmd_ready);
        end
    endtask

    task automatic test_pattern_only();
        load("", "^ab");
        grab("", "^ab");
        checks++; if (ns != 0) begin errs++; $display("FAIL patonly_str_beats got=%0d want=0", ns); end
        checks++; if (np != 3) begin errs++; $display("FAIL patonly_pat_beats got=%0d want=3", np); end
        checks++; if (bad || tmo || !lat) begin errs++; $display("FAIL patonly_seq bad=%b tmo=%b lat=%b", bad, tmo, lat); end
        reply(1'b1, 5'd0);
        checks++;
        if ({bus.res_valid, bus.res_match, bus.res_index, bus.res_err} !== 8'b1_1_00000_0) begin
            errs++; $display("FAIL patonly_res got=%b/%b/%0d/%b want=1/1/0/0", bus.res_valid, bus.res_match, bus.res_index, bus.res_err);
        end
        take_result();
    endtask

    task automatic test_overflow_hold();
        bit strobe_bad, res_bad, rdy_bad;
        strobe_bad = 0; res_bad = 0; rdy_bad = 0;
        for (int i = 0; i < 11; i++) send(CMD_PAT, CH_DOT);
        send(CMD_END, 8'd0);
        checks++;
        if ({bus.res_valid, bus.res_err, bus.res_match, bus.res_index} !== 8'b1_1_0_00000) begin
            errs++; $display("FAIL ovf_res got=%b/%b/%b/%0d want=1/1/0/0", bus.res_valid, bus.res_err, bus.res_match, bus.res_index);
        end
        for (int i = 0; i < 10; i++) begin
            if (bus.eng_isstring || bus.eng_ispattern || bus.eng_chardata !== 8'd0) strobe_bad = 1;
            if ({bus.res_valid, bus.res_err, bus.res_match, bus.res_index} !== 8'b1_1_0_00000) res_bad = 1;
            if (bus.cmd_ready !== 1'b0) rdy_bad = 1;
            @(negedge clk);
        end
        checks++; if (strobe_bad) begin errs++; $display("FAIL ovf_no_engine got=strobes want=none"); end
        checks++; if (res_bad) begin errs++; $display("FAIL hold_res_stable got=changed want=stable"); end
        checks++; if (rdy_bad) begin errs++; $display("FAIL hold_ready got=1 want=0"); end
        take_result();
        checks++;
        if ({bus.res_valid, bus.cmd_ready} !== 2'b01) begin
            errs++; $display("FAIL hold_release valid/ready got=%b%b want=01", bus.res_valid, bus.cmd_ready);
        end
    endtask

    task automatic test_restart();
        load("abc", "b.$");
        grab("abc", "b.$");
        checks++; if (ns != 3) begin errs++; $display("FAIL restart_str_beats got=%0d want=3", ns); end
        checks++; if (np != 3 || bad || tmo) begin errs++; $display("FAIL restart_seq np=%0d bad=%b want=3/0", np, bad); end
        reply(1'b1, 5'd1);
        checks++;
        if ({bus.res_err, bus.res_match, bus.res_index} !== 7'b0_1_00001) begin
            errs++; $display("FAIL restart_res got=%b/%b/%0d want=0/1/1", bus.res_err, bus.res_match, bus.res_index);
        end
        take_result();
    endtask

    task automatic test_flush();
        send(CMD_STR, 8'h7a);
        send(CMD_STR, 8'h7a);
        send(CMD_FLUSH, 8'd0);
        load("", "a");
        grab("", "a");
        checks++; if (ns != 0) begin errs++; $display("FAIL flush_str_beats got=%0d want=0", ns); end
        checks++; if (np != 1 || bad || tmo) begin errs++; $display("FAIL flush_seq np=%0d bad=%b want=1/0", np, bad); end
        reply(1'b0, 5'd0);
        take_result();
    endtask

    task automatic test_reset_mid_job();
        load("hello", "l");
        @(negedge clk);
        checks++;
        if (bus.eng_isstring !== 1'b1 || bus.eng_chardata !== 8'h65) begin
            errs++; $display("FAIL midrst_byte2 got=%b/%h want=1/65", bus.eng_isstring, bus.eng_chardata);
        end
        #1 reset = 1'b0;
        #1;
        checks++;
        if ({bus.eng_isstring, bus.eng_ispattern, bus.eng_chardata, bus.cmd_ready} !== 11'd0) begin
            errs++; $display("FAIL midrst_drop got=%b/%b/%h/%b want=0", bus.eng_isstring, bus.eng_ispattern, bus.eng_chardata, bus.cmd_ready);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++; if (bus.cmd_ready !== 1'b1) begin errs++; $display("FAIL midrst_ready got=%b want=1", bus.cmd_ready); end
        checks++; if (dut.str_cnt_q !== '0) begin errs++; $display("FAIL midrst_str_cnt got=%0d want=0", dut.str_cnt_q); end
        load("", "l");
        grab("", "l");
        checks++; if (ns != 0 || np != 1) begin errs++; $display("FAIL midrst_resend got=%0d/%0d want=0/1", ns, np); end
        reply(1'b0, 5'd0);
        take_result();
    endtask

`ifdef SME_CTRL_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        load("ab", "b");
        grab("ab", "b");
        n = 0;
        @(negedge clk);
        while (bus.res_valid !== 1'b1 && n < 200) begin n++; @(negedge clk); end
        checks++; if (n != 64) begin errs++; $display("FAIL tmo_cycles got=%0d want=64", n); end
        checks++;
        if ({bus.res_err, bus.res_match, bus.res_index} !== 7'b1_0_00000) begin
            errs++; $display("FAIL tmo_res got=%b/%b/%0d want=1/0/0", bus.res_err, bus.res_match, bus.res_index);
        end
        take_result();
        load("", "b");
        grab("ab", "b");
        checks++; if (ns != 2 || bad) begin errs++; $display("FAIL tmo_resend got=%0d bad=%b want=2/0", ns, bad); end
        reply(1'b1, 5'd1);
        take_result();
    endtask
`endif

    initial begin
        bus.cmd_valid = 1'b0; bus.cmd_type = '0; bus.cmd_data = '0;
        bus.eng_match = 1'b0; bus.eng_match_index = '0; bus.eng_valid = 1'b0;
        bus.res_ready = 1'b0;
        test_reset();
        test_basic();
        test_pattern_only();
        test_overflow_hold();
        test_restart();
        test_flush();
        test_reset_mid_job();
`ifdef SME_CTRL_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_time_limit got=running want=finished");
        $fatal(1, "time limit");
    end
endmodule
